// File: rtl/demux_hs.sv
// One-to-NUMOUT demultiplexer with a one-entry valid/ready holding register per lane.
// Words addressed to a lane index >= NUMOUT are dropped and counted in a saturating counter.
module demux_hs #(
    parameter int NUMOUT = 16,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16,
    localparam int SWIDTH = (NUMOUT > 1) ? $clog2(NUMOUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DWIDTH-1:0]        din,
    input  logic                     din_v,
    output logic                     din_rdy,
    input  logic [SWIDTH-1:0]        sel,
    output logic [NUMOUT*DWIDTH-1:0] dout_vec,
    output logic [NUMOUT-1:0]        dout_vec_v,
    input  logic [NUMOUT-1:0]        dout_vec_rdy,
    output logic [CWIDTH-1:0]        drop_cnt
);

    logic [NUMOUT*DWIDTH-1:0] r_data;
    logic [NUMOUT-1:0]        r_full;
    logic [CWIDTH-1:0]        r_dropCnt;

    logic [NUMOUT-1:0] w_selOneHot;
    logic              w_selHit;
    logic              w_selFull;
    logic              w_selRdy;
    logic              w_accept;
    logic [NUMOUT-1:0] w_load;

    // Decoding by comparison keeps out-of-range sel values from indexing past the lane vectors.
    always_comb begin
        w_selOneHot = '0;
        w_selFull   = 1'b0;
        w_selRdy    = 1'b0;
        for (int i = 0; i < NUMOUT; i++) begin
            if (sel == SWIDTH'(i)) begin
                w_selOneHot[i] = 1'b1;
                w_selFull      = r_full[i];
                w_selRdy       = dout_vec_rdy[i];
            end
        end
    end

    assign w_selHit = |w_selOneHot;
    assign din_rdy  = !w_selHit || !w_selFull || w_selRdy;
    assign w_accept = din_v && din_rdy;
    assign w_load   = w_accept ? w_selOneHot : '0;

    // A load takes priority over a drain, so a lane being drained and refilled stays full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_full    <= '0;
            r_dropCnt <= '0;
        end else begin
            for (int i = 0; i < NUMOUT; i++) begin
                if (w_load[i]) begin
                    r_data[i*DWIDTH +: DWIDTH] <= din;
                    r_full[i]                  <= 1'b1;
                end else if (r_full[i] && dout_vec_rdy[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (w_accept && !w_selHit && (r_dropCnt != {CWIDTH{1'b1}})) begin
                r_dropCnt <= r_dropCnt + CWIDTH'(1);
            end
        end
    end

    assign dout_vec   = r_data;
    assign dout_vec_v = r_full;
    assign drop_cnt   = r_dropCnt;

endmodule

// File: tb/tb_demux_hs.sv
// Directed bench for demux_hs: a 16-lane instance for the lane behaviour and a
// 10-lane, 4-bit-counter instance for the drop counter and its saturation.
module tb_demux_hs;

    typedef struct {
        logic [7:0]  din;
        logic [3:0]  sel;
        logic        dinV;
        logic [15:0] rdy;
        logic        expRdy;
        logic [15:0] expV;
        int          lane;
        logic [7:0]  expData;
    } vec_t;

    logic         clk;
    logic         rst;

    logic [7:0]   din16;
    logic         dinV16;
    logic         dinRdy16;
    logic [3:0]   sel16;
    logic [127:0] dout16;
    logic [15:0]  doutV16;
    logic [15:0]  rdy16;
    logic [15:0]  drop16;

    logic [7:0]   din10;
    logic         dinV10;
    logic         dinRdy10;
    logic [3:0]   sel10;
    logic [79:0]  dout10;
    logic [9:0]   doutV10;
    logic [9:0]   rdy10;
    logic [3:0]   drop10;

    int testsRun;
    int testsFailed;
    vec_t vecs[10];

    demux_hs u_dut16 (
        .clk          (clk),
        .rst          (rst),
        .din          (din16),
        .din_v        (dinV16),
        .din_rdy      (dinRdy16),
        .sel          (sel16),
        .dout_vec     (dout16),
        .dout_vec_v   (doutV16),
        .dout_vec_rdy (rdy16),
        .drop_cnt     (drop16)
    );

    demux_hs #(.NUMOUT(10), .DWIDTH(8), .CWIDTH(4)) u_dut10 (
        .clk          (clk),
        .rst          (rst),
        .din          (din10),
        .din_v        (dinV10),
        .din_rdy      (dinRdy10),
        .sel          (sel10),
        .dout_vec     (dout10),
        .dout_vec_v   (doutV10),
        .dout_vec_rdy (rdy10),
        .drop_cnt     (drop10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one vector at the falling edge, checks din_rdy combinationally,
    // then checks the registered lane outputs just after the next rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        din16  = v.din;
        sel16  = v.sel;
        dinV16 = v.dinV;
        rdy16  = v.rdy;
        #1;
        checkOutput($sformatf("vec%0d din_rdy", idx), {127'd0, dinRdy16}, {127'd0, v.expRdy});
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d dout_vec_v", idx), {112'd0, doutV16}, {112'd0, v.expV});
        checkOutput($sformatf("vec%0d lane%0d data", idx, v.lane),
                    {120'd0, dout16[v.lane*8 +: 8]}, {120'd0, v.expData});
    endtask

    task automatic drive10(input logic [7:0] d, input logic [3:0] s, input logic v, input logic [9:0] r);
        @(negedge clk);
        din10  = d;
        sel10  = s;
        dinV10 = v;
        rdy10  = r;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        //          din    sel   v     rdy        expRdy expV      lane expData
        vecs[0] = '{8'hA5, 4'd3, 1'b1, 16'hFFFF, 1'b1, 16'h0008, 3, 8'hA5};
        vecs[1] = '{8'h00, 4'd0, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 3, 8'hA5};
        vecs[2] = '{8'h11, 4'd5, 1'b1, 16'hFFDF, 1'b1, 16'h0020, 5, 8'h11};
        vecs[3] = '{8'h22, 4'd5, 1'b1, 16'hFFDF, 1'b0, 16'h0020, 5, 8'h11};
        vecs[4] = '{8'h22, 4'd6, 1'b1, 16'hFFDF, 1'b1, 16'h0060, 6, 8'h22};
        vecs[5] = '{8'h00, 4'd0, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 5, 8'h11};
        vecs[6] = '{8'h00, 4'd5, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 5, 8'h11};
        vecs[7] = '{8'h66, 4'd2, 1'b1, 16'hFFFF, 1'b1, 16'h0004, 2, 8'h66};
        vecs[8] = '{8'h77, 4'd2, 1'b1, 16'hFFFF, 1'b1, 16'h0004, 2, 8'h77};
        vecs[9] = '{8'h00, 4'd2, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 2, 8'h77};

        rst    = 1'b1;
        din16  = '0; sel16 = '0; dinV16 = 1'b0; rdy16 = '1;
        din10  = '0; sel10 = '0; dinV10 = 1'b0; rdy10 = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset dout_vec_v", {112'd0, doutV16}, 128'd0);
        checkOutput("reset dout_vec", dout16, 128'd0);
        checkOutput("reset drop_cnt", {112'd0, drop16}, 128'd0);
        checkOutput("reset din_rdy", {127'd0, dinRdy16}, 128'd1);
        checkOutput("reset drop_cnt10", {124'd0, drop10}, 128'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Back-to-back stream into lane 0 with the consumer always ready.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            din16 = 8'(k); sel16 = 4'd0; dinV16 = 1'b1; rdy16 = 16'hFFFF;
            #1;
            checkOutput($sformatf("stream%0d din_rdy", k), {127'd0, dinRdy16}, 128'd1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("stream%0d valid", k), {112'd0, doutV16}, 128'h0001);
            checkOutput($sformatf("stream%0d data", k), {120'd0, dout16[7:0]}, 128'(k));
        end
        @(negedge clk);
        dinV16 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("stream end valid", {112'd0, doutV16}, 128'd0);

        // Park a word in lane 9 of the 10-lane instance, then drop words aimed at lane 12.
        drive10(8'h5A, 4'd9, 1'b1, 10'h000);
        @(posedge clk);
        #1;
        checkOutput("d10 lane9 valid", {118'd0, doutV10}, 128'h200);
        for (int k = 0; k < 3; k++) begin
            drive10(8'hC3, 4'd12, 1'b1, 10'h000);
            #1;
            checkOutput($sformatf("d10 drop%0d din_rdy", k), {127'd0, dinRdy10}, 128'd1);
            @(posedge clk);
            #1;
        end
        checkOutput("d10 drop_cnt after 3", {124'd0, drop10}, 128'd3);
        checkOutput("d10 valid unchanged", {118'd0, doutV10}, 128'h200);
        checkOutput("d10 lane9 data", {120'd0, dout10[79:72]}, 128'h5A);
        for (int k = 3; k < 20; k++) begin
            drive10(8'hC3, 4'd12, 1'b1, 10'h000);
            @(posedge clk);
            #1;
            if (k == 14) begin
                checkOutput("d10 drop_cnt at 15", {124'd0, drop10}, 128'd15);
            end
        end
        checkOutput("d10 drop_cnt saturated", {124'd0, drop10}, 128'd15);
        drive10(8'h00, 4'd0, 1'b0, 10'h000);

        // Fill lanes 1, 4 and 9 against stalled consumers, then reset mid-handshake.
        rdy16 = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dinV16 = 1'b1;
            sel16  = (k == 0) ? 4'd1 : (k == 1) ? 4'd4 : 4'd9;
            din16  = (k == 0) ? 8'hAB : (k == 1) ? 8'hCD : 8'hEF;
            @(posedge clk);
            #1;
        end
        checkOutput("prefill valid", {112'd0, doutV16}, 128'h0212);
        @(negedge clk);
        dinV16 = 1'b0;
        sel16  = 4'd4;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst dout_vec_v", {112'd0, doutV16}, 128'd0);
        checkOutput("rst dout_vec", dout16, 128'd0);
        checkOutput("rst drop_cnt", {112'd0, drop16}, 128'd0);
        checkOutput("rst drop_cnt10", {124'd0, drop10}, 128'd0);
        checkOutput("rst valid10", {118'd0, doutV10}, 128'd0);
        @(negedge clk);
        rst   = 1'b0;
        rdy16 = 16'hFFFF;
        #1;
        checkOutput("post-rst din_rdy", {127'd0, dinRdy16}, 128'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("post-rst valid", {112'd0, doutV16}, 128'd0);
            checkOutput("post-rst data", dout16, 128'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
